sr_icache: RTL
==============

Name: sr_icache

Overview:
- Direct-mapped instruction cache between the single-cycle CPU fetch port and a slow word-wide backing instruction memory.
- Acts as responder on the CPU fetch handshake (im_req / im_addr in, im_data / im_drdy out).
- Acts as initiator of line refills on the memory side.
- Hits return one cycle after request and sustain one fetch per cycle back-to-back; misses refill a whole line and then respond.

Parameters:
- LINES, 16, number of cache lines; power of 2, at least 2.
- LINE_WORDS, 4, 32-bit words per line; power of 2, at least 2.
- Derived, not overridable: OFS_W = log2(LINE_WORDS), IDX_W = log2(LINES), TAG_W = 32 - OFS_W - IDX_W.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- im_req  in  1  fetch request strobe from CPU.
- im_addr  in  32  word address of the fetch, valid when im_req=1.
- im_data  out  32  fetched instruction, valid when im_drdy=1.
- im_drdy  out  1  one-cycle response strobe.
- mem_req  out  1  one-cycle refill request pulse.
- mem_addr  out  32  word address of the line base (offset bits = 0); held stable for the whole refill.
- mem_rdata  in  32  refill data beat.
- mem_rvalid  in  1  refill beat strobe.

Behaviour:
- Reset values:
  - state IDLE; all valid bits 0.
  - im_drdy=0, im_data=0, mem_req=0, mem_addr=0, beat counter 0.
- im_data is forced to 0 whenever im_drdy=0.
- Address split of the registered request address req_q:
  - offset = [OFS_W-1:0]
  - index = next IDX_W bits
  - tag = remaining TAG_W bits
- States and transitions:
  - IDLE: when im_req=1, capture im_addr into req_q and go to LOOKUP.
  - LOOKUP: compare valid[index] and tag[index] against req_q.
    - Hit: im_drdy=1 and im_data=data[index][offset] this cycle. If im_req=1 in the same cycle, capture the new address and stay in LOOKUP; otherwise go to IDLE.
    - Miss: im_drdy=0; go to FILL_REQ.
  - FILL_REQ: mem_req=1 for exactly this cycle with mem_addr = {tag,index,0}. Clear valid[index] and go to FILL.
  - FILL: each mem_rvalid writes mem_rdata into data[index][beat] and increments beat.
    - Beats arrive in order, offset 0 to LINE_WORDS-1, with arbitrary gaps.
    - On the last beat: write tag[index], set valid[index], reset beat to 0, go to LOOKUP.
    - The following LOOKUP always hits, so im_drdy is asserted the cycle after the last beat.
- Latency:
  - Hit: im_drdy one cycle after im_req.
  - Miss: 1 (lookup) + 1 (FILL_REQ) + memory latency + LINE_WORDS beats + 1 (post-fill lookup).
- im_req is honoured only in IDLE, or in LOOKUP in a cycle where im_drdy=1. Otherwise it is ignored; the bench flags it as a protocol violation.
- mem_rvalid outside FILL is ignored.
- Reset mid-FILL:
  - Aborts the refill and clears all valids.
  - Late beats after reset are ignored.
  - The CPU's post-reset request re-misses.
- Wrap: beat counter is OFS_W bits and wraps naturally to 0 after the last beat.
- Address aliasing: same index with a different tag evicts the line (no write-back; instruction side is read-only).

Optional Feature:
- Macro: ICACHE_STATS_EN.
- With the macro defined, two extra outputs: hit_cnt[31:0] and miss_cnt[31:0].
  - Both reset to 0; they wrap at 2^32.
  - hit_cnt increments on each first-lookup hit.
  - miss_cnt increments on each LOOKUP miss.
  - The post-fill lookup is not counted as a hit.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sr_icache_pkg holds:
  - state encoding (IDLE, LOOKUP, FILL_REQ, FILL);
  - width helper functions for OFS_W, IDX_W and TAG_W.
- One sub-module, sr_icache_array:
  - tag/valid/data storage in flops;
  - one combinational read port by index;
  - one write port for a data word;
  - one write port for tag plus valid set;
  - bulk valid clear on reset.
- FSM and counters live in sr_icache.

Test Plan:
- Cold miss: reset, im_req with im_addr=0x0.
  - Expect mem_req pulse with mem_addr=0x0.
  - Feed beats 0x11,0x22,0x33,0x44.
  - Expect im_drdy with im_data=0x11 the cycle after the 4th beat.
- Back-to-back hits: im_req im_addr=0x1,0x2,0x3, each in the im_drdy cycle.
  - Expect im_drdy on three consecutive cycles with data 0x22,0x33,0x44.
  - Expect no mem_req.
- Conflict eviction: fetch 0x40 (index 0, new tag).
  - Expect miss, mem_addr=0x40; refill 0xA0..0xA3.
  - Then fetch 0x0: expect miss again with mem_addr=0x0.
- Reset mid-fill: rst_n low after 2 of 4 beats; send 2 stray mem_rvalid in IDLE.
  - Then fetch 0x0: expect miss, fresh mem_req.
  - Expect correct data 0x11 after a full refill.
- Gapped refill: mem_rvalid low 3 cycles between each beat for fetch 0x7.
  - Expect mem_addr=0x4.
  - Expect im_data equals 4th beat value only after the final beat.
- With ICACHE_STATS_EN, after the first two scenarios: expect miss_cnt=1, hit_cnt=3.

Source files
------------

// File: rtl/sr_icache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
package sr_icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FILL_REQ,
        FILL
    } state_t;

    function automatic int ofs_width(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_width(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_width(input int lines, input int line_words);
        return 32 - $clog2(lines) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/sr_icache_array.sv
// Tag/valid/data storage for sr_icache: one combinational read port, a word
// write port, a tag write port that sets valid, and a single-line invalidate.
module sr_icache_array
    import sr_icache_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4,
    localparam int OFS_W     = ofs_width(LINE_WORDS),
    localparam int IDX_W     = idx_width(LINES),
    localparam int TAG_W     = tag_width(LINES, LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFS_W-1:0] rd_ofs,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_word,
    input  logic             wd_en,
    input  logic [IDX_W-1:0] wd_idx,
    input  logic [OFS_W-1:0] wd_ofs,
    input  logic [31:0]      wd_data,
    input  logic             tag_en,
    input  logic [IDX_W-1:0] tag_idx,
    input  logic [TAG_W-1:0] tag_data,
    input  logic             inv_en,
    input  logic [IDX_W-1:0] inv_idx
);

    logic [LINES-1:0]                       valid;
    logic [LINES-1:0][TAG_W-1:0]            tags;
    logic [LINES-1:0][LINE_WORDS-1:0][31:0] data;

    // Only valid bits need reset; tag/data are qualified by valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else begin
            if (inv_en) valid[inv_idx] <= 1'b0;
            if (tag_en) valid[tag_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wd_en)  data[wd_idx][wd_ofs] <= wd_data;
        if (tag_en) tags[tag_idx]        <= tag_data;
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_word  = data[rd_idx][rd_ofs];

endmodule

// File: rtl/sr_icache.sv
// Direct-mapped instruction cache: single-cycle hits, whole-line refill on miss.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module sr_icache
    import sr_icache_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        im_req,
    input  logic [31:0] im_addr,
    output logic [31:0] im_data,
    output logic        im_drdy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int OFS_W = ofs_width(LINE_WORDS);
    localparam int IDX_W = idx_width(LINES);
    localparam int TAG_W = tag_width(LINES, LINE_WORDS);

    state_t           state;
    logic [31:0]      req_q;
    logic [OFS_W-1:0] beat;

    logic [OFS_W-1:0] req_ofs;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_word;
    logic             hit;
    logic             fill_wr;
    logic             last_beat;

    assign req_ofs   = req_q[OFS_W-1:0];
    assign req_idx   = req_q[OFS_W +: IDX_W];
    assign req_tag   = req_q[OFS_W+IDX_W +: TAG_W];

    assign hit       = (state == LOOKUP) && rd_valid && (rd_tag == req_tag);
    assign fill_wr   = (state == FILL) && mem_rvalid;
    assign last_beat = fill_wr && (beat == OFS_W'(LINE_WORDS-1));

    assign im_drdy   = hit;
    assign im_data   = hit ? rd_word : '0;

    sr_icache_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (req_idx),
        .rd_ofs   (req_ofs),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_word  (rd_word),
        .wd_en    (fill_wr),
        .wd_idx   (req_idx),
        .wd_ofs   (beat),
        .wd_data  (mem_rdata),
        .tag_en   (last_beat),
        .tag_idx  (req_idx),
        .tag_data (req_tag),
        .inv_en   (state == FILL_REQ),
        .inv_idx  (req_idx)
    );

    // req_q stays frozen from the miss through the refill, so it also
    // supplies the fill index and the tag written on the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_q    <= '0;
            beat     <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            mem_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (im_req) begin
                        req_q <= im_addr;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (im_req) req_q <= im_addr;
                        else        state <= IDLE;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= {req_tag, req_idx, {OFS_W{1'b0}}};
                        state    <= FILL_REQ;
                    end
                end
                FILL_REQ: state <= FILL;
                FILL: begin
                    if (mem_rvalid) begin
                        beat <= beat + 1'b1;
                        if (last_beat) state <= LOOKUP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    logic post_fill;

    // The lookup right after a refill always hits and must not count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_fill <= 1'b0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            post_fill <= last_beat;
            if (state == LOOKUP) begin
                if (!hit)            miss_cnt <= miss_cnt + 32'd1;
                else if (!post_fill) hit_cnt  <= hit_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
